// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold-until-release ownership,
// optional hold-time limit and an optional idle gap between ownerships.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  localparam int HW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [HW-1:0] hold_cnt, cnt_n;
  logic [7:0]    gnt_n;
  logic [2:0]    idx_n;
  logic          tmo_n;

  logic [2:0] owner;
  logic       own_req, rel, expire, handoff;
  logic [7:0] arb_req;
  logic       found;
  logic [2:0] pick_idx;

  // First set bit of r in search order p, p+1, ... wrapping at 7.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] j;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      j = p + 3'(i);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  always_comb begin
    owner   = gnt_idx;
    own_req = req[owner];
    rel     = (state == GRANT) && !own_req;
    expire  = (state == GRANT) && (MAX_HOLD != 0) && own_req && (hold_cnt == LAST);
    handoff = rel || expire;
    ptr_n   = handoff ? owner + 3'd1 : ptr;
    // With no gap the next owner is chosen at the handoff edge, excluding the old owner.
    arb_req = 8'h00;
    if (state == IDLE) arb_req = req;
    else if (handoff && GAP == 0) arb_req = req & ~(8'h01 << owner);
    {found, pick_idx} = pick(arb_req, ptr_n);
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    cnt_n   = hold_cnt + HW'(1);
    tmo_n   = 1'b0;
    if (state == IDLE || handoff) begin
      tmo_n = expire;
      cnt_n = '0;
      if (found) begin
        state_n = GRANT;
        gnt_n   = 8'h01 << pick_idx;
        idx_n   = pick_idx;
      end else begin
        state_n = IDLE;
        gnt_n   = 8'h00;
        idx_n   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hold_cnt <= '0;
      gnt      <= 8'h00;
      gnt_idx  <= 3'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= cnt_n;
      gnt      <= gnt_n;
      gnt_idx  <= idx_n;
      timeout  <= tmo_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Round-robin arbiter sharing one downstream resource among 8 requesters. Each grant is presented both one-hot and as a 3-bit binary index, using the same encoding as the 8-to-3 encoder (y2..y0), for direct use as a mux select. Supports hold-until-release ownership with an optional hold-time limit, so no requester can starve the others.

Parameters:
MAX_HOLD, 16, max consecutive grant cycles per ownership; 0 = unlimited (timeout disabled)
GAP, 1, idle cycles inserted between ownerships; legal values 0 or 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  8  request lines; bit i = requester i; requester holds high for as long as it wants ownership
gnt  output  8  one-hot grant, registered
gnt_idx  output  3  binary index of granted requester, registered; 0 when gnt_valid=0
gnt_valid  output  1  high when any gnt bit is high
timeout  output  1  one-cycle pulse: ownership was revoked by MAX_HOLD

Behaviour:
- Single clock. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset, and rst_n low at any edge including mid-grant, gives: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state IDLE. Reset overrides all other events.
- State: ptr[2:0] is the highest-priority requester. Search order is ptr, ptr+1, ..., wrapping from 7 to 0.
- hold_cnt width is clog2(MAX_HOLD+1), minimum 1 bit.
- IDLE:
  - If req!=0 at an edge, grant the first set bit in search order, set hold_cnt=0, go to GRANT.
  - Latency: req sampled high in cycle k -> gnt visible in cycle k+1.
  - If req=0, remain in IDLE with outputs zero.
- GRANT (owner = gnt_idx):
  - hold_cnt increments each cycle.
  - release = !req[owner].
  - expire = (MAX_HOLD!=0) && req[owner] && (hold_cnt==MAX_HOLD-1).
  - If neither release nor expire, hold gnt unchanged. Other req changes are ignored during ownership.
- On release or expire at an edge:
  - ptr <= owner+1 (mod 8). The previous owner becomes lowest priority.
  - timeout <= expire. It is high for exactly one cycle, aligned with the first cycle in which the owner no longer holds gnt.
  - GAP=1: gnt=0 for one cycle (state IDLE), then normal IDLE arbitration.
  - GAP=0: arbitrate at the same edge with the new ptr and the owner's req bit masked. gnt switches directly to the next owner and gnt_valid stays 1. If no other request exists, go to IDLE (gnt=0).
- A held request owns gnt for exactly MAX_HOLD cycles.
- An expired requester still asserting req is re-granted only after all other pending requesters in rotation order. If it is the sole requester, it is re-granted after exactly one gnt=0 cycle for either GAP value.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_idx == binary encode of gnt (y2=|gnt[7:4], y1=gnt[2]|gnt[3]|gnt[6]|gnt[7], y0=odd bits).
  - Never grant a requester whose req was low at the granting edge.
- A req pulse that drops before being granted is lost. There is no request latching.

Test Plan:
- Reset: hold rst_n=0 two cycles with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0, timeout=0. Release reset: gnt=8'h01 one cycle later, gnt_idx=0.
- Rotation, GAP=1, MAX_HOLD=16: req=8'hFF, each owner drops its req after 3 cycles -> grant order 0,1,...,7,0. Each grant lasts 3 cycles. One gnt=0 cycle between grants. gnt_idx tracks 0..7.
- Wrap and skip: ptr=6 (after owner 5 releases), req=8'h22 -> gnt=8'h02 (idx 1). Then req=8'h20 -> gnt=8'h20 (idx 5).
- Timeout, MAX_HOLD=4: req[3] held high alone -> gnt=8'h08 for exactly 4 cycles. Then gnt=0 and timeout=1 for one cycle. Then re-grant to 3. With req[3]|req[4] held -> 4 granted after the timeout, not 3.
- GAP=0 back-to-back: req=8'h0C, owner 2 drops req -> next edge gnt=8'h08 directly, gnt_valid never deasserts.
- Mid-grant reset: during gnt=8'h10, drive rst_n=0 for one cycle -> gnt=0 at the next edge, ptr=0. With req=8'h11 after reset, requester 0 is granted first.
